// File: rtl/reset_sequencer.sv
// reset_sequencer: releases NUM_STAGES subsystem resets one at a time, each after a delay and an init-done ack.
// Optional DONE-state ack monitor: define RESET_SEQ_ACK_MONITOR_EN.
`default_nettype none

module reset_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 8,
  parameter int STAGE_DLY   = 4,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  sw_rst_req_i,
  input  logic [NUM_STAGES-1:0] stage_ack_i,
  output logic [NUM_STAGES-1:0] stage_rst_o,
  output logic [2:0]            stage_idx_o,
  output logic                  seq_done_o,
  output logic                  seq_err_o
);

  localparam int MAX_HD  = (HOLD_CYCLES > STAGE_DLY) ? HOLD_CYCLES : STAGE_DLY;
  localparam int MAX_CNT = (MAX_HD > ACK_TIMEOUT) ? MAX_HD : ACK_TIMEOUT;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] DLY_LAST  = CW'(STAGE_DLY - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(ACK_TIMEOUT - 1);
  localparam logic [2:0]    LAST_IDX  = 3'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    S_HOLD     = 3'd0,
    S_DELAY    = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_DONE     = 3'd3,
    S_ERROR    = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [2:0]            idx, idx_nxt;
  logic [NUM_STAGES-1:0] rst_vec, rst_vec_nxt;
  logic                  done, done_nxt;
  logic                  err, err_nxt;
  logic                  ack_cur;
  logic                  ack_all;
  logic [2:0]            low_idx;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= S_HOLD;
      cnt     <= '0;
      idx     <= 3'd0;
      rst_vec <= '1;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      rst_vec <= rst_vec_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
    end
  end

  // Only the ack of the stage currently being sequenced matters; higher stages are not yet released.
  always_comb begin
    ack_cur = 1'b0;
    low_idx = 3'd0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (int'(idx) == i) ack_cur = stage_ack_i[i];
    end
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (!stage_ack_i[i]) low_idx = 3'(i);
    end
    ack_all = &stage_ack_i;
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    idx_nxt     = idx;
    rst_vec_nxt = rst_vec;
    done_nxt    = done;
    err_nxt     = err;

    if (sw_rst_req_i) begin
      cnt_nxt = '0;
      if (state != S_HOLD) begin
        state_nxt   = S_HOLD;
        idx_nxt     = 3'd0;
        rst_vec_nxt = '1;
        done_nxt    = 1'b0;
      end
    end else begin
      case (state)
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            state_nxt = S_DELAY;
            idx_nxt   = 3'd0;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end

        S_DELAY: begin
          if (cnt == DLY_LAST) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
              if (int'(idx) == i) rst_vec_nxt[i] = 1'b0;
            end
            state_nxt = S_WAIT_ACK;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end

        // Timeout is tested before the ack so a coincident ack loses.
        S_WAIT_ACK: begin
          if (cnt == TO_LAST) begin
            state_nxt   = S_ERROR;
            rst_vec_nxt = '1;
            err_nxt     = 1'b1;
            done_nxt    = 1'b0;
          end else if (ack_cur) begin
            cnt_nxt = '0;
            if (idx == LAST_IDX) begin
              state_nxt   = S_DONE;
              done_nxt    = 1'b1;
              rst_vec_nxt = '0;
            end else begin
              state_nxt = S_DELAY;
              idx_nxt   = idx + 3'd1;
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end

        S_DONE: begin
`ifdef RESET_SEQ_ACK_MONITOR_EN
          if (!ack_all) begin
            state_nxt   = S_HOLD;
            cnt_nxt     = '0;
            idx_nxt     = low_idx;
            rst_vec_nxt = '1;
            done_nxt    = 1'b0;
            err_nxt     = 1'b1;
          end
`else
          state_nxt = S_DONE;
`endif
        end

        S_ERROR: begin
          state_nxt = S_ERROR;
        end

        default: begin
          state_nxt   = S_HOLD;
          cnt_nxt     = '0;
          idx_nxt     = 3'd0;
          rst_vec_nxt = '1;
          done_nxt    = 1'b0;
        end
      endcase
    end
  end

`ifndef RESET_SEQ_ACK_MONITOR_EN
  // Without the monitor, the lowest-failing-index search and all-ack reduction have no consumer.
  logic unused_monitor;
  assign unused_monitor = ack_all ^ (^low_idx);
`endif

  assign stage_rst_o = rst_vec;
  assign stage_idx_o = idx;
  assign seq_done_o  = done;
  assign seq_err_o   = err;

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed literal scenarios plus randomized stimulus checked every cycle against a timestamp-based model.
`default_nettype none

module tb_reset_sequencer;

  localparam int NS  = 3;
  localparam int HC  = 8;
  localparam int DLY = 4;
  localparam int TO  = 64;

  localparam int P_HOLD  = 0;
  localparam int P_DELAY = 1;
  localparam int P_WAIT  = 2;
  localparam int P_DONE  = 3;
  localparam int P_ERR   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sw  = 1'b0;
  logic [NS-1:0] ack = '0;
  logic [NS-1:0] stage_rst;
  logic [2:0]    stage_idx;
  logic          seq_done;
  logic          seq_err;

  reset_sequencer #(
    .NUM_STAGES (NS),
    .HOLD_CYCLES(HC),
    .STAGE_DLY  (DLY),
    .ACK_TIMEOUT(TO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .sw_rst_req_i(sw),
    .stage_ack_i (ack),
    .stage_rst_o (stage_rst),
    .stage_idx_o (stage_idx),
    .seq_done_o  (seq_done),
    .seq_err_o   (seq_err)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int fails  = 0;
  int tcount = 0;  // absolute edge count
  int ecount = 0;  // edges since the last edge that sampled rst high

  // Model: phase mirroring the FSM state names, entry timestamp, number of released stages.
  int ph    = P_HOLD;
  int ent   = 0;
  int midx  = 0;
  int nrel  = 0;
  bit mdone = 1'b0;
  bit merr  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ecount);
    end
  endtask

  function automatic logic [NS-1:0] exp_rst();
    logic [NS-1:0] v = '1;
    for (int i = 0; i < NS; i++) if (i < nrel) v[i] = 1'b0;
    return v;
  endfunction

  function automatic void model(input bit r, input bit s, input logic [NS-1:0] a);
    int el;
    tcount++;
    if (r) begin
      ph = P_HOLD; ent = tcount; midx = 0; nrel = 0; mdone = 0; merr = 0;
    end else if (s) begin
      if (ph != P_HOLD) begin
        ph = P_HOLD; midx = 0; nrel = 0; mdone = 0;
      end
      ent = tcount;
    end else begin
      el = tcount - ent;
      case (ph)
        P_HOLD:  if (el == HC) begin ph = P_DELAY; ent = tcount; midx = 0; end
        P_DELAY: if (el == DLY) begin nrel = midx + 1; ph = P_WAIT; ent = tcount; end
        P_WAIT: begin
          if (el == TO) begin
            ph = P_ERR; nrel = 0; merr = 1; mdone = 0;
          end else if (a[midx]) begin
            if (midx == NS - 1) begin ph = P_DONE; mdone = 1; end
            else begin midx++; ph = P_DELAY; ent = tcount; end
          end
        end
        P_DONE: begin
`ifdef RESET_SEQ_ACK_MONITOR_EN
          if (a != '1) begin
            for (int i = NS - 1; i >= 0; i--) if (!a[i]) midx = i;
            ph = P_HOLD; ent = tcount; nrel = 0; mdone = 0; merr = 1;
          end
`endif
        end
        default: ;
      endcase
    end
  endfunction

  task automatic step(input bit r, input bit s, input logic [NS-1:0] a);
    @(negedge clk);
    rst = r; sw = s; ack = a;
    @(posedge clk);
    model(r, s, a);
    if (r) ecount = 0; else ecount++;
    #1;
    chk("stage_rst", int'(stage_rst), int'(exp_rst()));
    chk("stage_idx", int'(stage_idx), midx);
    chk("seq_done", int'(seq_done), int'(mdone));
    chk("seq_err", int'(seq_err), int'(merr));
  endtask

  task automatic do_reset();
    step(1, 0, '0);
    step(1, 0, '0);
  endtask

  initial begin
    int p;
    int n;
    logic [NS-1:0] a;

    // All acks high: releases at 12, 17, 22; done after 23.
    do_reset();
    chk("reset_rst", int'(stage_rst), 7);
    chk("reset_done", int'(seq_done), 0);
    for (int k = 1; k <= 30; k++) begin
      step(0, 0, 3'b111);
      if (ecount == 11) chk("s1_rst_e11", int'(stage_rst), 7);
      if (ecount == 12) chk("s1_rst_e12", int'(stage_rst), 6);
      if (ecount == 16) chk("s1_rst_e16", int'(stage_rst), 6);
      if (ecount == 17) chk("s1_rst_e17", int'(stage_rst), 4);
      if (ecount == 22) chk("s1_rst_e22", int'(stage_rst), 0);
      if (ecount == 22) chk("s1_done_e22", int'(seq_done), 0);
      if (ecount == 23) chk("s1_done_e23", int'(seq_done), 1);
      if (ecount == 23) chk("s1_err_e23", int'(seq_err), 0);
    end

    // Software re-sequence from DONE; N = 30, request sampled at N+1.
    step(0, 1, 3'b111);
    chk("sw_rst_all", int'(stage_rst), 7);
    chk("sw_done_clr", int'(seq_done), 0);
    for (int k = 0; k < 30; k++) begin
      step(0, 0, 3'b111);
      if (ecount == 42) chk("sw_rst_e42", int'(stage_rst), 7);
      if (ecount == 43) chk("sw_rst_e43", int'(stage_rst), 6);
      if (ecount == 48) chk("sw_rst_e48", int'(stage_rst), 4);
      if (ecount == 53) chk("sw_rst_e53", int'(stage_rst), 0);
    end

    // Stage 1 never acks: timeout at edge 81.
    do_reset();
    for (int k = 1; k <= 85; k++) begin
      step(0, 0, 3'b101);
      if (ecount == 17) chk("to_rst_e17", int'(stage_rst), 4);
      if (ecount == 80) chk("to_err_e80", int'(seq_err), 0);
      if (ecount == 81) chk("to_rst_e81", int'(stage_rst), 7);
      if (ecount == 81) chk("to_err_e81", int'(seq_err), 1);
      if (ecount == 81) chk("to_idx_e81", int'(stage_idx), 1);
    end
    // sw clears the error state but not the sticky flag.
    step(0, 1, 3'b111);
    chk("err_sticky_sw", int'(seq_err), 1);

    // rst pulsed at edge 15 restarts identical timing.
    do_reset();
    for (int k = 1; k <= 14; k++) step(0, 0, 3'b111);
    step(1, 0, 3'b111);
    chk("rst15_rst", int'(stage_rst), 7);
    chk("rst15_idx", int'(stage_idx), 0);
    for (int k = 1; k <= 25; k++) begin
      step(0, 0, 3'b111);
      if (ecount == 12) chk("rst15_e12", int'(stage_rst), 6);
      if (ecount == 22) chk("rst15_e22", int'(stage_rst), 0);
    end

    // Early ack on stage 2 ignored; stages 0 and 1 ack 10 cycles late.
    do_reset();
    for (int k = 1; k <= 45; k++) begin
      a = 3'b100;
      if (ecount + 1 >= 22) a[0] = 1'b1;
      if (ecount + 1 >= 36) a[1] = 1'b1;
      step(0, 0, a);
      if (ecount == 39) chk("late_rst_e39", int'(stage_rst), 4);
      if (ecount == 40) chk("late_rst_e40", int'(stage_rst), 0);
      if (ecount == 41) chk("late_done_e41", int'(seq_done), 1);
      if (ecount == 41) chk("late_err_e41", int'(seq_err), 0);
    end

    // Drop ack[1] for one cycle in DONE.
    step(0, 0, 3'b101);
`ifdef RESET_SEQ_ACK_MONITOR_EN
    chk("mon_err", int'(seq_err), 1);
    chk("mon_idx", int'(stage_idx), 1);
    chk("mon_rst", int'(stage_rst), 7);
    for (int k = 0; k < 30; k++) step(0, 0, 3'b111);
    chk("mon_redone", int'(seq_done), 1);
`else
    chk("nomon_err", int'(seq_err), 0);
    chk("nomon_done", int'(seq_done), 1);
    chk("nomon_rst", int'(stage_rst), 0);
`endif

    // Randomized episodes.
    for (int e = 0; e < 24; e++) begin
      do_reset();
      case ($urandom_range(0, 3))
        0:       p = 100;
        1:       p = 40;
        2:       p = 6;
        default: p = 2;
      endcase
      n = 200 + int'($urandom_range(0, 150));
      for (int k = 0; k < n; k++) begin
        for (int i = 0; i < NS; i++) a[i] = ($urandom_range(0, 99) < p);
        step(($urandom_range(0, 799) == 0), ($urandom_range(0, 149) == 0), a);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
